// File: rtl/cdb_arbiter_if.sv
// Common data bus arbitration interface: four result requesters on one side,
// the arbiter and its registered broadcast on the other.
//
// Handshake: a requester raises Req[i] with TagIn/DataIn slice i valid and
// holds all three stable until it sees Grant[i] high (combinational, same
// cycle). The rising Clock edge with Grant[i]=1 is the transfer. The requester
// then drops Req[i] the following cycle unless it has a new result ready.
// Nothing is queued on the arbiter side, so an ungranted request that is
// withdrawn simply vanishes. The broadcast is valid for exactly the cycles
// in which CdbValid is high.
interface cdb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
);
  logic                  Run;
  logic [3:0]            Req;
  logic [4*TAG_W-1:0]    TagIn;
  logic [4*DATA_W-1:0]   DataIn;
  logic [3:0]            Grant;
  logic                  CdbValid;
  logic [TAG_W-1:0]      CdbTag;
  logic [DATA_W-1:0]     CdbData;
  logic                  Conflict;
  logic [1:0]            Ptr;

  // Requester / environment side
  modport master (
    output Run, Req, TagIn, DataIn,
    input  Grant, CdbValid, CdbTag, CdbData, Conflict, Ptr
  );

  // Arbiter side
  modport slave (
    input  Run, Req, TagIn, DataIn,
    output Grant, CdbValid, CdbTag, CdbData, Conflict, Ptr
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for a four-source common data bus. One requester is
// granted per enabled cycle; its tag and result are registered onto the bus
// at the granting edge and the rotating pointer moves just past the winner,
// so no continuously requesting source waits more than four enabled cycles.
module cdb_arbiter #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  cdb_arbiter_if.slave  bus
);

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
  logic [1:0]        ptr_q,       ptr_d;

  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic [1:0] idx;
  logic       found;
  logic       multi_req;

  // Priority search starting at the pointer, wrapping modulo four.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    if (!Reset && bus.Run) begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr_q + 2'(k);
        if (!found && bus.Req[idx]) begin
          found     = 1'b1;
          grant_idx = idx;
        end
      end
    end
    if (found) begin
      grant = 4'b0001 << grant_idx;
    end
  end

  // Two or more requests present: x & (x-1) clears the lowest set bit.
  always_comb begin
    multi_req = ((bus.Req & (bus.Req - 4'd1)) != 4'd0);
  end

  // Next broadcast and pointer: capture the winner, otherwise hold tag/data.
  always_comb begin
    cdb_valid_d = found;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    ptr_d       = ptr_q;
    if (found) begin
      cdb_tag_d  = bus.TagIn[grant_idx*TAG_W +: TAG_W];
      cdb_data_d = bus.DataIn[grant_idx*DATA_W +: DATA_W];
      ptr_d      = grant_idx + 2'd1;
    end
  end

  // Broadcast and pointer registers; reset drops any pending arbitration.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      ptr_q       <= 2'd0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.Grant    = grant;
  assign bus.Conflict = bus.Run & ~Reset & multi_req;
  assign bus.CdbValid = cdb_valid_q;
  assign bus.CdbTag   = cdb_tag_q;
  assign bus.CdbData  = cdb_data_q;
  assign bus.Ptr      = ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single grant, round-robin rotation,
// pointer wrap, Run gating, dropped requests and reset with pending requests.
module tb_cdb_arbiter;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;

  logic Clock;
  logic Reset;
  int   checks;
  int   fails;

  cdb_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // Clock and time limit
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_src(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    bus.TagIn[i*TAG_W +: TAG_W]    = t;
    bus.DataIn[i*DATA_W +: DATA_W] = d;
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Reset   = 1'b1;
    bus.Run = 1'b1;
    bus.Req = 4'b1111;
    for (int i = 0; i < 4; i++) set_src(i, TAG_W'(i + 1), 16'h5500 + 16'(i));
    checks++; if (bus.Grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b want 0000", bus.Grant); end
    checks++; if (bus.Conflict !== 1'b0) begin fails++; $display("FAIL reset_conflict: got %b want 0", bus.Conflict); end
    tick();
    checks++; if (bus.CdbValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.CdbValid); end
    checks++; if (bus.Ptr !== 2'd0) begin fails++; $display("FAIL reset_ptr: got %0d want 0", bus.Ptr); end
    checks++; if (bus.CdbTag !== 3'd0) begin fails++; $display("FAIL reset_tag: got %0d want 0", bus.CdbTag); end
    checks++; if (bus.CdbData !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h want 0000", bus.CdbData); end
    Reset   = 1'b0;
    bus.Req = 4'b0000;
    #1;
  endtask

  task automatic test_single();
    set_src(2, 3'd5, 16'h00A7);
    bus.Req = 4'b0100;
    #1;
    checks++; if (bus.Grant !== 4'b0100) begin fails++; $display("FAIL single_grant: got %b want 0100", bus.Grant); end
    checks++; if (bus.Conflict !== 1'b0) begin fails++; $display("FAIL single_conflict: got %b want 0", bus.Conflict); end
    tick();
    bus.Req = 4'b0000;
    checks++; if (bus.CdbValid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", bus.CdbValid); end
    checks++; if (bus.CdbTag !== 3'd5) begin fails++; $display("FAIL single_tag: got %0d want 5", bus.CdbTag); end
    checks++; if (bus.CdbData !== 16'h00A7) begin fails++; $display("FAIL single_data: got %h want 00a7", bus.CdbData); end
    checks++; if (bus.Ptr !== 2'd3) begin fails++; $display("FAIL single_ptr: got %0d want 3", bus.Ptr); end
    tick();
    checks++; if (bus.CdbValid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b want 0", bus.CdbValid); end
    checks++; if (bus.CdbTag !== 3'd5) begin fails++; $display("FAIL idle_tag_hold: got %0d want 5", bus.CdbTag); end
    checks++; if (bus.CdbData !== 16'h00A7) begin fails++; $display("FAIL idle_data_hold: got %h want 00a7", bus.CdbData); end
    checks++; if (bus.Ptr !== 2'd3) begin fails++; $display("FAIL idle_ptr_hold: got %0d want 3", bus.Ptr); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g;
    logic [1:0] exp_p;
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, TAG_W'(i + 2), 16'hA000 + 16'(i * 17));
    bus.Req = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_p = 2'((k + 1) % 4);
      checks++; if (bus.Grant !== exp_g) begin fails++; $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.Grant, exp_g); end
      checks++; if (bus.Conflict !== 1'b1) begin fails++; $display("FAIL rr_conflict[%0d]: got %b want 1", k, bus.Conflict); end
      tick();
      checks++; if (bus.CdbValid !== 1'b1) begin fails++; $display("FAIL rr_valid[%0d]: got %b want 1", k, bus.CdbValid); end
      checks++; if (bus.CdbTag !== TAG_W'((k % 4) + 2)) begin fails++; $display("FAIL rr_tag[%0d]: got %0d want %0d", k, bus.CdbTag, (k % 4) + 2); end
      checks++; if (bus.CdbData !== 16'hA000 + 16'((k % 4) * 17)) begin fails++; $display("FAIL rr_data[%0d]: got %h want %h", k, bus.CdbData, 16'hA000 + 16'((k % 4) * 17)); end
      checks++; if (bus.Ptr !== exp_p) begin fails++; $display("FAIL rr_ptr[%0d]: got %0d want %0d", k, bus.Ptr, exp_p); end
    end
    bus.Req = 4'b0000;
    #1;
  endtask

  task automatic test_wrap();
    bus.Req = 4'b0100;
    tick();
    checks++; if (bus.Ptr !== 2'd3) begin fails++; $display("FAIL wrap_setup_ptr: got %0d want 3", bus.Ptr); end
    bus.Req = 4'b1001;
    #1;
    checks++; if (bus.Grant !== 4'b1000) begin fails++; $display("FAIL wrap_grant3: got %b want 1000", bus.Grant); end
    tick();
    checks++; if (bus.Ptr !== 2'd0) begin fails++; $display("FAIL wrap_ptr0: got %0d want 0", bus.Ptr); end
    bus.Req = 4'b0001;
    #1;
    checks++; if (bus.Grant !== 4'b0001) begin fails++; $display("FAIL wrap_grant0: got %b want 0001", bus.Grant); end
    tick();
    checks++; if (bus.Ptr !== 2'd1) begin fails++; $display("FAIL wrap_ptr1: got %0d want 1", bus.Ptr); end
    bus.Req = 4'b0000;
    tick();
  endtask

  task automatic test_run_hold();
    int bcast0;
    int bcast1;
    bcast0 = 0;
    bcast1 = 0;
    do_reset();
    set_src(0, 3'd6, 16'h1234);
    set_src(1, 3'd7, 16'hBEEF);
    bus.Run = 1'b0;
    bus.Req = 4'b0011;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.Grant !== 4'b0000) begin fails++; $display("FAIL hold_grant[%0d]: got %b want 0000", k, bus.Grant); end
      checks++; if (bus.Conflict !== 1'b0) begin fails++; $display("FAIL hold_conflict[%0d]: got %b want 0", k, bus.Conflict); end
      tick();
      checks++; if (bus.CdbValid !== 1'b0) begin fails++; $display("FAIL hold_valid[%0d]: got %b want 0", k, bus.CdbValid); end
      checks++; if (bus.Ptr !== 2'd0) begin fails++; $display("FAIL hold_ptr[%0d]: got %0d want 0", k, bus.Ptr); end
    end
    bus.Run = 1'b1;
    #1;
    checks++; if (bus.Grant !== 4'b0001) begin fails++; $display("FAIL resume_grant0: got %b want 0001", bus.Grant); end
    // Requester side: drop Req the cycle after its grant; tally broadcasts.
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.CdbValid === 1'b1 && bus.CdbTag === 3'd6) bcast0++;
      if (bus.CdbValid === 1'b1 && bus.CdbTag === 3'd7) bcast1++;
      if (k == 0) bus.Req = 4'b0010;
      else        bus.Req = 4'b0000;
      #1;
    end
    checks++; if (bcast0 !== 1) begin fails++; $display("FAIL resume_bcast0: got %0d want 1", bcast0); end
    checks++; if (bcast1 !== 1) begin fails++; $display("FAIL resume_bcast1: got %0d want 1", bcast1); end
    checks++; if (bus.CdbData !== 16'hBEEF) begin fails++; $display("FAIL resume_last_data: got %h want beef", bus.CdbData); end
    checks++; if (bus.Ptr !== 2'd2) begin fails++; $display("FAIL resume_ptr: got %0d want 2", bus.Ptr); end
  endtask

  task automatic test_drop();
    set_src(3, 3'd4, 16'hDEAD);
    bus.Run = 1'b0;
    bus.Req = 4'b1000;
    tick();
    bus.Req = 4'b0000;
    bus.Run = 1'b1;
    #1;
    checks++; if (bus.Grant !== 4'b0000) begin fails++; $display("FAIL drop_grant: got %b want 0000", bus.Grant); end
    tick();
    checks++; if (bus.CdbValid !== 1'b0) begin fails++; $display("FAIL drop_valid: got %b want 0", bus.CdbValid); end
    checks++; if (bus.CdbData !== 16'hBEEF) begin fails++; $display("FAIL drop_data: got %h want beef", bus.CdbData); end
  endtask

  task automatic test_reset_pending();
    set_src(1, 3'd3, 16'h0F0F);
    bus.Req = 4'b0010;
    #1;
    checks++; if (bus.Grant !== 4'b0010) begin fails++; $display("FAIL rstp_grant: got %b want 0010", bus.Grant); end
    tick();
    Reset = 1'b1;
    #1;
    checks++; if (bus.Grant !== 4'b0000) begin fails++; $display("FAIL rstp_grant_in_reset: got %b want 0000", bus.Grant); end
    tick();
    checks++; if (bus.CdbValid !== 1'b0) begin fails++; $display("FAIL rstp_valid: got %b want 0", bus.CdbValid); end
    checks++; if (bus.Ptr !== 2'd0) begin fails++; $display("FAIL rstp_ptr: got %0d want 0", bus.Ptr); end
    Reset = 1'b0;
    #1;
    checks++; if (bus.Grant !== 4'b0010) begin fails++; $display("FAIL rstp_regrant: got %b want 0010", bus.Grant); end
    tick();
    checks++; if (bus.CdbValid !== 1'b1) begin fails++; $display("FAIL rstp_valid2: got %b want 1", bus.CdbValid); end
    checks++; if (bus.CdbData !== 16'h0F0F) begin fails++; $display("FAIL rstp_data: got %h want 0f0f", bus.CdbData); end
    checks++; if (bus.Ptr !== 2'd2) begin fails++; $display("FAIL rstp_ptr2: got %0d want 2", bus.Ptr); end
    bus.Req = 4'b0000;
    tick();
  endtask

  initial begin
    checks     = 0;
    fails      = 0;
    Reset      = 1'b1;
    bus.Run    = 1'b0;
    bus.Req    = 4'b0000;
    bus.TagIn  = '0;
    bus.DataIn = '0;
    @(negedge Clock);
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_run_hold();
    test_drop();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
